riscv_fetch_stage: RTL

RISCV_FETCH_STAGE -- requirements
Module: riscv_fetch_stage

---
 rtl/riscv_fetch_stage.sv | 119 +++++++++++
 1 files changed

// File: rtl/riscv_fetch_stage.sv
// ============================================================================
// Module  : riscv_fetch_stage
// Brief   : RISC-V IF stage: PC register, RUN/HALT fetch FSM and IF/ID register.
// Revision: 1.0
// ============================================================================
`default_nettype none

module riscv_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rd,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic        halted
);

  localparam logic [31:0] c_stop_word = 32'h00000000;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_pc_plus4;
  logic        w_stop;
  logic        w_idle;

  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pc_plus4_d;
  logic        r_valid_d;

  assign w_pc_plus4 = r_pc + 32'd4;

  // A STOP word only counts when it would actually be consumed this cycle.
  assign w_stop = (r_state == RUN) && !stall_f && !pc_src_e && (imem_rd == c_stop_word);
  assign w_idle = (r_state == HALT) || w_stop;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_stop)   w_state_nxt = HALT;
      HALT:    if (pc_src_e) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    w_pc_nxt = w_pc_plus4;
    if (pc_src_e)     w_pc_nxt = {pc_target_e[31:2], 2'b00};
    else if (stall_f) w_pc_nxt = r_pc;
    else if (w_idle)  w_pc_nxt = r_pc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // IF/ID register: flush beats stall; halt/stop inserts bubbles so STOP never goes valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= 32'd0;
      r_pc_plus4_d <= 32'd0;
      r_valid_d    <= 1'b0;
    end else if (flush_d) begin
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= 32'd0;
      r_pc_plus4_d <= 32'd0;
      r_valid_d    <= 1'b0;
    end else if (stall_d) begin
      r_instr_d    <= r_instr_d;
      r_pc_d       <= r_pc_d;
      r_pc_plus4_d <= r_pc_plus4_d;
      r_valid_d    <= r_valid_d;
    end else if (w_idle) begin
      r_instr_d    <= NOP_INSTR;
      r_pc_d       <= 32'd0;
      r_pc_plus4_d <= 32'd0;
      r_valid_d    <= 1'b0;
    end else begin
      r_instr_d    <= imem_rd;
      r_pc_d       <= r_pc;
      r_pc_plus4_d <= w_pc_plus4;
      r_valid_d    <= 1'b1;
    end
  end

  assign imem_addr  = r_pc;
  assign instr_d    = r_instr_d;
  assign pc_d       = r_pc_d;
  assign pc_plus4_d = r_pc_plus4_d;
  assign valid_d    = r_valid_d;
  assign halted     = (r_state == HALT);

endmodule

`default_nettype wire
